elevator_scan_controller: RTL and testbench

//  Parametrised multi-request elevator controller, N floors, SCAN (elevator) scheduling.

---
 rtl/elevator_pkg.sv | 14 +
 rtl/elevator_if.sv | 28 ++
 rtl/elevator_tick_timer.sv | 25 ++
 rtl/elevator_scan_controller.sv | 150 +++++++++++++++
 tb/tb_elevator_scan_controller.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/elevator_pkg.sv
// Shared types for the SCAN elevator controller.
// Holds the state encoding and the default timer width.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        DOOR_OPEN = 2'b01,
        MOVE_UP   = 2'b10,
        MOVE_DOWN = 2'b11
    } state_t;

    localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/elevator_if.sv
// Request/status bundle between floor-select logic and the controller.
// master: drives req_valid/req_floor, reads status; slave: the controller.
interface elevator_if #(
    parameter int NUM_FLOORS = 10,
    parameter int FLOOR_W    = 4
);
    logic                  req_valid;
    logic [FLOOR_W-1:0]    req_floor;
    logic [FLOOR_W-1:0]    current_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  dir_up;
    logic                  moving;
    logic                  door_open;
    logic                  idle;
    logic                  arrived;

    modport master (
        output req_valid, req_floor,
        input  current_floor, pending, dir_up,
        input  moving, door_open, idle, arrived
    );

    modport slave (
        input  req_valid, req_floor,
        output current_floor, pending, dir_up,
        output moving, door_open, idle, arrived
    );
endinterface

// File: rtl/elevator_tick_timer.sv
// Down-counter shared by travel and door dwell timing.
// Ports: clk, reset, load, load_val in; done out (count is zero).
module elevator_tick_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == '0);
endmodule

// File: rtl/elevator_scan_controller.sv
// SCAN-scheduled elevator: latches requests, moves a floor per travel time.
// Ports: clk, reset, bus (elevator_if.slave: requests in, status out).
module elevator_scan_controller
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = 10,
    parameter int FLOOR_W      = 4,
    parameter int TRAVEL_TICKS = 10000000,
    parameter int DOOR_TICKS   = 20000000,
    parameter int CNT_W        = CNT_W_DEF
) (
    input logic       clk,
    input logic       reset,
    elevator_if.slave bus
);
    localparam logic [NUM_FLOORS-1:0] ONE  = NUM_FLOORS'(1);
    localparam logic [NUM_FLOORS-1:0] ALL  = '1;
    localparam logic [CNT_W-1:0]      T_LD = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [CNT_W-1:0]      D_LD = CNT_W'(DOOR_TICKS - 1);

    state_t                state, d_next;
    logic [FLOOR_W-1:0]    cur_floor, step_floor;
    logic [NUM_FLOORS-1:0] pending, pend_nx, set_mask;
    logic [NUM_FLOORS-1:0] up_mask, dn_mask, cur_mask, step_mask;
    logic                  dir_up, arrived;
    logic                  req_ok, door_hit, here, ahead, behind, stop;
    logic                  d_flip, tmr_load, tmr_done;
    logic [CNT_W-1:0]      tmr_val;

    elevator_tick_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        up_mask   = ALL << cur_floor;
        up_mask   = up_mask << 1;
        dn_mask   = ~(ALL << cur_floor);
        cur_mask  = ONE << cur_floor;
        step_floor = (state == MOVE_DOWN) ? cur_floor - FLOOR_W'(1)
                                          : cur_floor + FLOOR_W'(1);
        step_mask = ONE << step_floor;

        req_ok   = bus.req_valid && (32'(bus.req_floor) < NUM_FLOORS);
        // A repeat call for the floor being served holds the door instead.
        door_hit = req_ok && (state == DOOR_OPEN)
                   && (bus.req_floor == cur_floor);
        set_mask = (req_ok && !door_hit) ? (ONE << bus.req_floor) : '0;
        pend_nx  = pending | set_mask;

        here   = |(pending & cur_mask);
        ahead  = |(pending & (dir_up ? up_mask : dn_mask));
        behind = |(pending & (dir_up ? dn_mask : up_mask));
        // Includes a request arriving on the stepping cycle itself.
        stop   = |(pend_nx & step_mask);

        d_next = IDLE;
        d_flip = 1'b0;
        if (ahead) begin
            d_next = dir_up ? MOVE_UP : MOVE_DOWN;
        end else if (behind) begin
            d_next = dir_up ? MOVE_DOWN : MOVE_UP;
            d_flip = 1'b1;
        end

        tmr_load = 1'b0;
        tmr_val  = T_LD;
        unique case (state)
            IDLE: begin
                if (here) begin
                    tmr_load = 1'b1;
                    tmr_val  = D_LD;
                end else if (d_next != IDLE) begin
                    tmr_load = 1'b1;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (stop) tmr_val = D_LD;
                end
            end
            DOOR_OPEN: begin
                if (door_hit) begin
                    tmr_load = 1'b1;
                    tmr_val  = D_LD;
                end else if (tmr_done && d_next != IDLE) begin
                    tmr_load = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_floor <= '0;
            pending   <= '0;
            dir_up    <= 1'b1;
            arrived   <= 1'b0;
        end else begin
            arrived <= 1'b0;
            pending <= pend_nx;
            unique case (state)
                IDLE: begin
                    if (here) begin
                        pending <= pend_nx & ~cur_mask;
                        state   <= DOOR_OPEN;
                        arrived <= 1'b1;
                    end else if (d_next != IDLE) begin
                        state <= d_next;
                        if (d_flip) dir_up <= ~dir_up;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (tmr_done) begin
                        cur_floor <= step_floor;
                        if (stop) begin
                            pending <= pend_nx & ~step_mask;
                            state   <= DOOR_OPEN;
                            arrived <= 1'b1;
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (!door_hit && tmr_done) begin
                        state <= d_next;
                        if (d_flip) dir_up <= ~dir_up;
                    end
                end
            endcase
        end
    end

    assign bus.current_floor = cur_floor;
    assign bus.pending       = pending;
    assign bus.dir_up        = dir_up;
    assign bus.moving        = (state == MOVE_UP) || (state == MOVE_DOWN);
    assign bus.door_open     = (state == DOOR_OPEN);
    assign bus.idle          = (state == IDLE);
    assign bus.arrived       = arrived;

    floor_in_range: assert property (
        @(posedge clk) disable iff (reset)
        32'(cur_floor) < NUM_FLOORS
    );
endmodule

// File: tb/tb_elevator_scan_controller.sv
// Directed bench for elevator_scan_controller (8 floors, travel 4, dwell 3).
// Arrival floors are queued at request time and checked on each arrived pulse.
module tb_elevator_scan_controller;
    import elevator_pkg::*;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   max_floor = 0;
    int   sb[$];

    elevator_if #(.NUM_FLOORS(8), .FLOOR_W(4)) bus();

    elevator_scan_controller #(
        .NUM_FLOORS   (8),
        .FLOOR_W      (4),
        .TRAVEL_TICKS (4),
        .DOOR_TICKS   (3),
        .CNT_W        (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every arrival must match the next queued floor.
    always @(negedge clk) begin
        if (!reset) begin
            if (int'(bus.current_floor) > max_floor)
                max_floor = int'(bus.current_floor);
            if (bus.arrived === 1'b1) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL arrive_unexpected: observed floor=%0d expected none",
                           bus.current_floor);
                end
                if (sb.size() != 0)
                    chk("arrive_floor", 32'(bus.current_floor),
                        32'(sb.pop_front()));
            end
        end
    end

    task automatic req(input int f);
        bus.req_valid = 1'b1;
        bus.req_floor = 4'(f);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_floor = '0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((sb.size() != 0 || bus.idle !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({"done_", tag}, 32'(sb.size() == 0 && bus.idle === 1'b1), 1);
    endtask

    task automatic wait_floor(input int f);
        int n = 0;
        while (int'(bus.current_floor) != f && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_floor", 32'(bus.current_floor), 32'(f));
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_floor = '0;
        cycles(2);
        chk("rst_idle", 32'(bus.idle), 1);
        chk("rst_moving", 32'(bus.moving), 0);
        chk("rst_door", 32'(bus.door_open), 0);
        chk("rst_arrived", 32'(bus.arrived), 0);
        chk("rst_floor", 32'(bus.current_floor), 0);
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_dir", 32'(bus.dir_up), 1);
        reset = 1'b0;
        cycles(1);

        // Floor 0 -> 3 with exact step timing.
        sb.push_back(3);
        req(3);
        chk("r3_pending", 32'(bus.pending), 32'h08);
        chk("r3_still_idle", 32'(bus.idle), 1);
        cycles(1);
        chk("r3_moving", 32'(bus.moving), 1);
        cycles(3);
        chk("r3_f0_hold", 32'(bus.current_floor), 0);
        cycles(1);
        chk("r3_f1", 32'(bus.current_floor), 1);
        cycles(4);
        chk("r3_f2", 32'(bus.current_floor), 2);
        cycles(4);
        chk("r3_f3", 32'(bus.current_floor), 3);
        chk("r3_arrived", 32'(bus.arrived), 1);
        chk("r3_door", 32'(bus.door_open), 1);
        cycles(1);
        chk("r3_arr_pulse", 32'(bus.arrived), 0);
        cycles(1);
        chk("r3_door_last", 32'(bus.door_open), 1);
        cycles(1);
        chk("r3_idle", 32'(bus.idle), 1);
        chk("r3_pend_clr", 32'(bus.pending), 0);

        // Up to 6, call for 1 issued while passing 4.
        sb.push_back(6);
        req(6);
        wait_floor(4);
        sb.push_back(1);
        req(1);
        n = 0;
        while (!(bus.moving === 1'b1 && bus.dir_up === 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scan_reverse_dir", 32'(bus.dir_up), 0);
        chk("scan_reverse_floor", 32'(bus.current_floor), 6);
        wait_done("scan");
        chk("scan_floor", 32'(bus.current_floor), 1);
        chk("scan_pending", 32'(bus.pending), 0);

        // Out-of-range requests are dropped.
        req(9);
        chk("r9_pending", 32'(bus.pending), 0);
        req(15);
        cycles(1);
        chk("r15_pending", 32'(bus.pending), 0);
        chk("r15_idle", 32'(bus.idle), 1);

        // Top floor.
        sb.push_back(7);
        req(7);
        wait_done("top");
        chk("top_floor", 32'(bus.current_floor), 7);
        chk("top_max", 32'(max_floor), 7);

        // Go to 2, then call 2 while idle there.
        sb.push_back(2);
        req(2);
        wait_done("to2");
        chk("to2_dir", 32'(bus.dir_up), 0);
        sb.push_back(2);
        req(2);
        chk("same_pending", 32'(bus.pending), 32'h04);
        cycles(1);
        chk("same_door", 32'(bus.door_open), 1);
        chk("same_floor", 32'(bus.current_floor), 2);
        chk("same_pend_clr", 32'(bus.pending), 0);
        req(2);
        chk("ext_door", 32'(bus.door_open), 1);
        chk("ext_pending", 32'(bus.pending), 0);
        cycles(2);
        chk("ext_door_held", 32'(bus.door_open), 1);
        chk("ext_pending2", 32'(bus.pending), 0);
        cycles(1);
        chk("ext_idle", 32'(bus.idle), 1);

        // Call 6, then call 5 on the very cycle the car enters 5.
        req(6);
        wait_floor(4);
        cycles(3);
        sb.push_back(5);
        sb.push_back(6);
        req(5);
        chk("sim_floor", 32'(bus.current_floor), 5);
        chk("sim_door", 32'(bus.door_open), 1);
        chk("sim_pending", 32'(bus.pending), 32'h40);
        wait_done("sim");
        chk("sim_final", 32'(bus.current_floor), 6);

        // Asynchronous reset in the middle of a trip.
        req(0);
        req(3);
        cycles(2);
        chk("pre_rst_moving", 32'(bus.moving), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_floor", 32'(bus.current_floor), 0);
        chk("mid_rst_pending", 32'(bus.pending), 0);
        chk("mid_rst_idle", 32'(bus.idle), 1);
        chk("mid_rst_arrived", 32'(bus.arrived), 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        cycles(1);
        sb.push_back(4);
        req(4);
        wait_done("post_rst");
        chk("post_rst_floor", 32'(bus.current_floor), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
